// File: rtl/usb_rx_nrzi_sync_if.sv
// Line-sample input and decoded-stream output bundle for the USB receive front end.
interface usb_rx_nrzi_sync_if;
  logic       bit_strobe;
  logic [1:0] usb_line_state;
  logic       sync_detected;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       rx_error;

  modport master (
    output bit_strobe, usb_line_state,
    input  sync_detected, rx_bit, rx_bit_valid, rx_error
  );

  modport slave (
    input  bit_strobe, usb_line_state,
    output sync_detected, rx_bit, rx_bit_valid, rx_error
  );
endinterface

// File: rtl/usb_rx_nrzi_sync.sv
// USB receive front end: NRZI decode, SYNC hunt and bit-unstuffing, one bit per strobe.
// state   | meaning
// HUNT    | counting decoded 0s, waiting for the 1 that ends SYNC
// ACTIVE  | delivering data bits, removing stuffed 0s
// EOP     | SE0 seen, waiting for the J/K that returns the bus to idle
// DISCARD | packet aborted, data ignored until SE0
module usb_rx_nrzi_sync #(
  parameter int MIN_SYNC_ZEROS = 5,
  parameter int STUFF_LEN      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  usb_rx_nrzi_sync_if.slave     rx
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [2:0]    MIN_ZEROS = 3'(MIN_SYNC_ZEROS);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_K   = 2'b10;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  typedef enum logic [1:0] {HUNT, ACTIVE, EOP, DISCARD} state_t;

  state_t        state, state_nxt;
  logic [1:0]    prev_line, prev_line_nxt;
  logic [2:0]    zero_cnt, zero_cnt_nxt;
  logic [OW-1:0] ones_cnt, ones_cnt_nxt;
  logic          sync_q, sync_nxt;
  logic          bit_q, bit_nxt;
  logic          valid_q, valid_nxt;
  logic          err_q, err_nxt;

  logic [1:0] line;
  logic       is_jk;
  logic       dec;

  assign line  = rx.usb_line_state;
  assign is_jk = (line == LINE_J) || (line == LINE_K);
  assign dec   = (line == prev_line);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      prev_line <= LINE_J;
      zero_cnt  <= '0;
      ones_cnt  <= '0;
      sync_q    <= 1'b0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_line <= prev_line_nxt;
      zero_cnt  <= zero_cnt_nxt;
      ones_cnt  <= ones_cnt_nxt;
      sync_q    <= sync_nxt;
      bit_q     <= bit_nxt;
      valid_q   <= valid_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    prev_line_nxt = prev_line;
    zero_cnt_nxt  = zero_cnt;
    ones_cnt_nxt  = ones_cnt;
    sync_nxt      = 1'b0;
    bit_nxt       = bit_q;
    valid_nxt     = 1'b0;
    err_nxt       = 1'b0;

    if (rx.bit_strobe) begin
      // SE0/SE1 carry no NRZI information, so only J/K move the reference level
      if (is_jk) prev_line_nxt = line;

      unique case (state)
        HUNT: begin
          if (is_jk && !dec) begin
            if (zero_cnt != 3'd7) zero_cnt_nxt = zero_cnt + 3'd1;
          end else begin
            zero_cnt_nxt = '0;
            if (is_jk && zero_cnt >= MIN_ZEROS) begin
              sync_nxt     = 1'b1;
              ones_cnt_nxt = OW'(1);
              state_nxt    = ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (is_jk) begin
            if (ones_cnt == STUFF_MAX) begin
              if (dec) begin
                err_nxt   = 1'b1;
                state_nxt = DISCARD;
              end else begin
                ones_cnt_nxt = '0;
              end
            end else begin
              bit_nxt      = dec;
              valid_nxt    = 1'b1;
              ones_cnt_nxt = dec ? ones_cnt + OW'(1) : '0;
            end
          end else if (line == LINE_SE0) begin
            state_nxt = EOP;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = DISCARD;
          end
        end
        EOP: begin
          if (is_jk) begin
            zero_cnt_nxt = '0;
            state_nxt    = HUNT;
          end else if (line == LINE_SE1) begin
            err_nxt   = 1'b1;
            state_nxt = DISCARD;
          end
        end
        DISCARD: begin
          if (line == LINE_SE0) state_nxt = EOP;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign rx.sync_detected = sync_q;
  assign rx.rx_bit        = bit_q;
  assign rx.rx_bit_valid  = valid_q;
  assign rx.rx_error      = err_q;

endmodule
